// File: rtl/prm_edge_scan_sched.sv
// Walks a run of check vectors through a combinational obstacle checker and packs its mask bits into WORD_W-bit words.
// One vector per cycle; the first word is ready min(count, WORD_W) cycles after a request is accepted.
// When the output register is still occupied as a new word completes, the scan stalls; optional hit counter under PRM_SCHED_HITCNT_EN.
module prm_edge_scan_sched #(
    parameter int VEC_W  = 15,
    parameter int CNT_W  = 16,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VEC_W-1:0]  req_base,
    input  logic [CNT_W-1:0]  req_count,
    input  logic              abort,
    output logic [VEC_W-1:0]  chk_vec,
    input  logic              chk_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_nbits,
    output logic              out_last,
`ifdef PRM_SCHED_HITCNT_EN
    output logic [CNT_W-1:0]  hit_cnt,
`endif
    output logic              busy,
    output logic              done
);
    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_left;
    logic [WORD_W-1:0]   acc;
    logic [IDX_W-1:0]    acc_n;
    logic                accept, sample, need_load, stall, last_vec, kill;

    assign last_vec  = (cnt_left == CNT_W'(1));
    assign kill      = abort && (state_q != S_IDLE);
    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sample    = 1'b0;
        need_load = 1'b0;
        stall     = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        accept  = 1'b1;
                        state_d = (req_count == '0) ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A completed word can only be pushed if the holding register frees up this cycle.
                    need_load = (acc_n == IDX_W'(WORD_W - 1)) || last_vec;
                    stall     = need_load && out_valid && !out_ready;
                    sample    = !stall;
                    if (sample && last_vec) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_ready) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vec   <= '0;
            cnt_left  <= '0;
            acc       <= '0;
            acc_n     <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_nbits <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                chk_vec  <= req_base;
                cnt_left <= req_count;
                acc      <= '0;
                acc_n    <= '0;
            end
            if (sample) begin
                chk_vec  <= chk_vec + VEC_W'(1);
                cnt_left <= cnt_left - CNT_W'(1);
                if (need_load) begin
                    acc   <= '0;
                    acc_n <= '0;
                end else begin
                    acc[acc_n] <= chk_mask;
                    acc_n      <= acc_n + IDX_W'(1);
                end
            end
            if (kill) begin
                out_valid <= 1'b0;
            end else if (sample && need_load) begin
                out_valid <= 1'b1;
                out_word  <= acc | (WORD_W'(chk_mask) << acc_n);
                out_nbits <= 6'(acc_n) + 6'd1;
                out_last  <= last_vec;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PRM_SCHED_HITCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   hit_cnt <= '0;
        else if (accept)                              hit_cnt <= '0;
        else if (sample && chk_mask && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_prm_edge_scan_sched.sv
// Randomized bench for prm_edge_scan_sched: a reference model builds expected words from the scan rules.
module tb_prm_edge_scan_sched;
    localparam int VEC_W  = 15;
    localparam int CNT_W  = 16;
    localparam int WORD_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [VEC_W-1:0]  req_base;
    logic [CNT_W-1:0]  req_count;
    logic              abort;
    logic [VEC_W-1:0]  chk_vec;
    logic              chk_mask;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic [5:0]        out_nbits;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef PRM_SCHED_HITCNT_EN
    logic [CNT_W-1:0]  hit_cnt;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    int          mask_mode = 0;
    logic [14:0] mask_key = '0;

    always #5 clk = ~clk;

    prm_edge_scan_sched #(.VEC_W(VEC_W), .CNT_W(CNT_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_count(req_count), .abort(abort),
        .chk_vec(chk_vec), .chk_mask(chk_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_nbits(out_nbits), .out_last(out_last),
`ifdef PRM_SCHED_HITCNT_EN
        .hit_cnt(hit_cnt),
`endif
        .busy(busy), .done(done)
    );

    // Obstacle checker stand-in: a pure function of the presented vector.
    function automatic logic mask_fn(input logic [14:0] v, input int mode, input logic [14:0] key);
        case (mode)
            0:       return v[0];
            1:       return 1'b1;
            2:       return ^(v & key);
            default: return (v < key);
        endcase
    endfunction

    assign chk_mask = mask_fn(chk_vec, mask_mode, mask_key);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and consumes its words; hold = cycles out_ready is forced low.
    task automatic run_scan(input logic [14:0] base, input int count, input int rdy_pct,
                            input int hold, output int done_lat);
        logic [31:0] ew[$];
        int          en[$];
        int          nwords, nw, cyc, budget, hits;
        logic        got_done, held;
        logic [31:0] hw;
        logic [5:0]  hn;
        logic [14:0] v;

        nwords = (count + WORD_W - 1) / WORD_W;
        hits   = 0;
        for (int k = 0; k < nwords; k++) begin
            logic [31:0] w;
            int n;
            w = '0;
            n = (count - k * WORD_W > WORD_W) ? WORD_W : count - k * WORD_W;
            for (int i = 0; i < n; i++) begin
                v = base + 15'(k * WORD_W + i);
                w[i] = mask_fn(v, mask_mode, mask_key);
                if (w[i]) hits++;
            end
            ew.push_back(w);
            en.push_back(n);
        end

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_base  = base;
        req_count = CNT_W'(count);
        out_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc      = 1;
        nw       = 0;
        got_done = 1'b0;
        held     = 1'b0;
        hw       = '0;
        hn       = '0;
        done_lat = -1;
        budget   = hold + count * 8 + 100;
        while (!got_done && cyc < budget) begin
            if (done) begin
                got_done = 1'b1;
                done_lat = cyc;
`ifdef PRM_SCHED_HITCNT_EN
                chk("hit_cnt", hit_cnt, hits);
`endif
            end
            chk("busy_active", busy, 1);
            if (cyc <= count && cyc <= WORD_W) chk("scan_vec", chk_vec, 15'(base + 15'(cyc - 1)));
            if (hold > 0 && cyc == hold) begin
                chk("stall_vec", chk_vec, 15'(base + 15'(2 * WORD_W - 1)));
                chk("stall_ovld", out_valid, 1);
            end
            if (held) begin
                chk("hold_word", out_word, hw);
                chk("hold_nbits", out_nbits, hn);
            end
            out_ready = (cyc > hold) && ($urandom_range(0, 99) < rdy_pct);
            if (out_valid && out_ready) begin
                if (nw < nwords) begin
                    chk("word", out_word, ew[nw]);
                    chk("nbits", out_nbits, en[nw]);
                    chk("last", out_last, (nw == nwords - 1));
                end else begin
                    chk("extra_word", 1, 0);
                end
                nw++;
            end
            held = out_valid && !out_ready;
            hw   = out_word;
            hn   = out_nbits;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("done_seen", got_done, 1);
        chk("nwords", nw, nwords);
        chk("idle_after_done", busy, 0);
        chk("done_pulse_1cyc", done, 0);
    endtask

    // Starts a scan and aborts it at the given cycle after accept.
    task automatic abort_scan(input logic [14:0] base, input int count, input int at, input logic rdy);
        @(negedge clk);
        req_valid = 1'b1;
        req_base  = base;
        req_count = CNT_W'(count);
        out_ready = rdy;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (at - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ovld", out_valid, 0);
        chk("abort_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", done, 0);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_base  = '0;
        req_count = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovld", out_valid, 0);
        chk("rst_vec", chk_vec, 0);
        chk("rst_word", out_word, 0);
        chk("rst_nbits", out_nbits, 0);
        chk("rst_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;

        mask_mode = 0;
        run_scan(15'h0000, 32, 100, 0, lat);
        chk("done_lat_32", (lat >= 33 && lat <= 35), 1);

        mask_mode = 1;
        run_scan(15'h7FFE, 4, 100, 0, lat);

        mask_mode = 2;
        mask_key  = 15'($urandom);
        run_scan(15'($urandom), 70, 100, 100, lat);

        mask_mode = 1;
        run_scan(15'h0123, 0, 100, 0, lat);
        chk("done_lat_0", (lat >= 1 && lat <= 2), 1);

        abort_scan(15'h0040, 100, 10, 1'b1);
        mask_mode = 2;
        mask_key  = 15'h5A5A;
        run_scan(15'h0100, 40, 100, 0, lat);
        abort_scan(15'h0200, 100, 40, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_idle_ignored", busy, 0);
        abort = 1'b0;
        run_scan(15'h7FF0, 45, 70, 0, lat);

        mask_mode = 3;
        mask_key  = 15'd7;
        run_scan(15'h0000, 20, 100, 0, lat);

        for (int t = 0; t < 8; t++) begin
            mask_mode = 2;
            mask_key  = 15'($urandom);
            run_scan(15'($urandom), $urandom_range(1, 150), $urandom_range(30, 100), 0, lat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
